// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: timer FSM states and
// EXE operand forwarding source selects.
// Latency: n/a (types/constants only). Backpressure: n/a.
package pipe_ctrl_pkg;

    // Memory-wait timer FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN  = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // EXE operand source select
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REG = 2'd0;
    localparam fwd_sel_t FWD_MEM = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of stage-status inputs and stage-control outputs of the hazard controller.
// Latency: n/a (wiring only). Backpressure: n/a; the controller itself is the stall source.
// Modports: master = pipeline side (drives stage status), slave = controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_LEN = 4
);
    import pipe_ctrl_pkg::*;

    // stage status from the pipeline registers
    logic [REG_ADDR_LEN-1:0] id_src1;
    logic [REG_ADDR_LEN-1:0] id_src2;
    logic                    id_src2_use;
    logic [REG_ADDR_LEN-1:0] exe_src1;
    logic [REG_ADDR_LEN-1:0] exe_src2;
    logic [REG_ADDR_LEN-1:0] exe_dest;
    logic                    exe_wb_en;
    logic                    exe_mem_rd;
    logic [REG_ADDR_LEN-1:0] mem_dest;
    logic                    mem_wb_en;
    logic                    mem_acc;
    logic [REG_ADDR_LEN-1:0] wb_dest;
    logic                    wb_wb_en;
    logic                    branch_taken;

    // stage control back to the pipeline registers
    logic     if_en;
    logic     id_en;
    logic     exe_en;
    logic     mem_en;
    logic     wb_en;
    logic     id_flush;
    logic     exe_flush;
    logic     wb_flush;
    fwd_sel_t fwd_sel_a;
    fwd_sel_t fwd_sel_b;
    logic     mem_busy;

    modport master (
        output id_src1, id_src2, id_src2_use, exe_src1, exe_src2, exe_dest,
               exe_wb_en, exe_mem_rd, mem_dest, mem_wb_en, mem_acc,
               wb_dest, wb_wb_en, branch_taken,
        input  if_en, id_en, exe_en, mem_en, wb_en, id_flush, exe_flush,
               wb_flush, fwd_sel_a, fwd_sel_b, mem_busy
    );

    modport slave (
        input  id_src1, id_src2, id_src2_use, exe_src1, exe_src2, exe_dest,
               exe_wb_en, exe_mem_rd, mem_dest, mem_wb_en, mem_acc,
               wb_dest, wb_wb_en, branch_taken,
        output if_en, id_en, exe_en, mem_en, wb_en, id_flush, exe_flush,
               wb_flush, fwd_sel_a, fwd_sel_b, mem_busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// Data-memory wait timer: holds mem_stall for exactly MEM_WAIT cycles per access.
// Latency: mem_stall is combinational on the access cycle; release cycle follows the last stall cycle.
// Backpressure: during the DONE release cycle mem_acc is ignored so the frozen access can retire.
// Ports: clk, rst (sync, active-high), mem_acc in, mem_stall out.
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 4,
    parameter int CNT_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_acc,
    output logic mem_stall
);

    // Counter preload: the RUN cycle and the cnt==0 WAIT cycle are both stall
    // cycles, so MEM_WAIT-2 extra WAIT cycles remain.
    localparam logic [CNT_LEN-1:0] CNT_INIT = CNT_LEN'((MEM_WAIT >= 2) ? (MEM_WAIT - 2) : 0);

    state_t             state_q, state_d;
    logic [CNT_LEN-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_acc) begin
                    if (MEM_WAIT == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_LEN'(1);
                end
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign mem_stall = ((state_q == ST_RUN) && mem_acc) || (state_q == ST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage enables/bubbles from memory stall, branch flush, load-use.
// Latency: outputs are combinational from timer state and current inputs.
// Backpressure: memory stall freezes IF..MEM and bubbles WB; hazards freeze IF/ID for one slot.
// Ports: clk, rst (sync, active-high), bus (pipe_hazard_ctrl_if.slave).
// Build option FORWARDING_EN: EXE forwarding selects, only load-use hazards stall.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_LEN = 4,
    parameter int MEM_WAIT     = 4,
    parameter int CNT_LEN      = 3
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    function automatic logic reg_match(input logic [REG_ADDR_LEN-1:0] r,
                                       input logic [REG_ADDR_LEN-1:0] s1,
                                       input logic [REG_ADDR_LEN-1:0] s2,
                                       input logic                    s2_use);
        return (r == s1) || (s2_use && (r == s2));
    endfunction

    function automatic fwd_sel_t fwd_pick(input logic [REG_ADDR_LEN-1:0] src,
                                          input logic                    m_wb,
                                          input logic [REG_ADDR_LEN-1:0] m_dst,
                                          input logic                    w_wb,
                                          input logic [REG_ADDR_LEN-1:0] w_dst);
        // MEM holds the younger result, so it wins over WB
        if (m_wb && (m_dst == src))      return FWD_MEM;
        else if (w_wb && (w_dst == src)) return FWD_WB;
        else                             return FWD_REG;
    endfunction

    logic     mem_stall;
    logic     hazard;
    fwd_sel_t fwd_a, fwd_b;

    mem_wait_timer #(
        .MEM_WAIT (MEM_WAIT),
        .CNT_LEN  (CNT_LEN)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .mem_acc   (bus.mem_acc),
        .mem_stall (mem_stall)
    );

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time
    assign hazard = bus.exe_wb_en && bus.exe_mem_rd &&
                    reg_match(bus.exe_dest, bus.id_src1, bus.id_src2, bus.id_src2_use);
    assign fwd_a  = fwd_pick(bus.exe_src1, bus.mem_wb_en, bus.mem_dest, bus.wb_wb_en, bus.wb_dest);
    assign fwd_b  = fwd_pick(bus.exe_src2, bus.mem_wb_en, bus.mem_dest, bus.wb_wb_en, bus.wb_dest);
`else
    // Without forwarding any in-flight producer in EXE or MEM blocks ID
    assign hazard = (bus.exe_wb_en && reg_match(bus.exe_dest, bus.id_src1, bus.id_src2, bus.id_src2_use)) ||
                    (bus.mem_wb_en && reg_match(bus.mem_dest, bus.id_src1, bus.id_src2, bus.id_src2_use));
    assign fwd_a  = FWD_REG;
    assign fwd_b  = FWD_REG;
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{bus.exe_src1, bus.exe_src2, bus.exe_mem_rd, bus.wb_dest, bus.wb_wb_en,
                                 fwd_pick(bus.exe_src1, 1'b0, '0, 1'b0, '0)};
`endif

    always_comb begin
        bus.if_en     = 1'b1;
        bus.id_en     = 1'b1;
        bus.exe_en    = 1'b1;
        bus.mem_en    = 1'b1;
        bus.wb_en     = 1'b1;
        bus.id_flush  = 1'b0;
        bus.exe_flush = 1'b0;
        bus.wb_flush  = 1'b0;
        bus.fwd_sel_a = FWD_REG;
        bus.fwd_sel_b = FWD_REG;
        bus.mem_busy  = 1'b0;
        if (!rst) begin
            bus.fwd_sel_a = fwd_a;
            bus.fwd_sel_b = fwd_b;
            if (mem_stall) begin
                // EXE is frozen, so a pending branch is seen again after release
                bus.if_en    = 1'b0;
                bus.id_en    = 1'b0;
                bus.exe_en   = 1'b0;
                bus.mem_en   = 1'b0;
                bus.wb_flush = 1'b1;
                bus.mem_busy = 1'b1;
            end else if (bus.branch_taken) begin
                // squashes the ID instruction too, so any hazard on it is moot
                bus.id_flush  = 1'b1;
                bus.exe_flush = 1'b1;
            end else if (hazard) begin
                bus.if_en     = 1'b0;
                bus.id_en     = 1'b0;
                bus.exe_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // observed vector: {if,id,exe,mem,wb, id_flush,exe_flush,wb_flush, fwd_a, fwd_b, mem_busy}
    typedef logic [12:0] obs_t;
    localparam obs_t NORM   = {5'b11111, 3'b000, 2'd0, 2'd0, 1'b0};
    localparam obs_t STALL  = {5'b00001, 3'b001, 2'd0, 2'd0, 1'b1};
    localparam obs_t BRANCH = {5'b11111, 3'b110, 2'd0, 2'd0, 1'b0};
    localparam obs_t HAZ    = {5'b00111, 3'b010, 2'd0, 2'd0, 1'b0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_ADDR_LEN(4)) bus ();

    pipe_hazard_ctrl #(
        .REG_ADDR_LEN (4),
        .MEM_WAIT     (4),
        .CNT_LEN      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic obs_t observe();
        return {bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en,
                bus.id_flush, bus.exe_flush, bus.wb_flush,
                bus.fwd_sel_a, bus.fwd_sel_b, bus.mem_busy};
    endfunction

    task automatic clear_inputs();
        bus.id_src1      = 4'd0;
        bus.id_src2      = 4'd0;
        bus.id_src2_use  = 1'b0;
        bus.exe_src1     = 4'hF;
        bus.exe_src2     = 4'hF;
        bus.exe_dest     = 4'd0;
        bus.exe_wb_en    = 1'b0;
        bus.exe_mem_rd   = 1'b0;
        bus.mem_dest     = 4'd0;
        bus.mem_wb_en    = 1'b0;
        bus.mem_acc      = 1'b0;
        bus.wb_dest      = 4'd0;
        bus.wb_wb_en     = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    // load-use stimulus: ldr r2 in EXE / add r3,r2,r1 in ID
    task automatic set_load_use();
        bus.exe_wb_en   = 1'b1;
        bus.exe_mem_rd  = 1'b1;
        bus.exe_dest    = 4'd2;
        bus.id_src1     = 4'd2;
        bus.id_src2     = 4'd1;
        bus.id_src2_use = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, exp_v;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            bus.mem_acc      = 1'b1;
            bus.branch_taken = 1'b1;
            set_load_use();
            bus.exe_src1  = 4'd7;
            bus.mem_dest  = 4'd7;
            bus.mem_wb_en = 1'b1;
            sb.push_back(NORM);
            @(negedge clk);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL reset[%0d] got=%b exp=%b", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    // mem_acc held: two accesses back to back, each 4 stall cycles + 1 release
    task automatic test_mem_stall();
        obs_t got, exp_v;
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            bus.mem_acc = (i < 10);
            sb.push_back((i < 10 && (i % 5) != 4) ? STALL : NORM);
            @(negedge clk);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL mem_stall[%0d] got=%b exp=%b", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic       ewb, erd;
        logic [3:0] edst;
        logic       mwb;
        logic [3:0] mdst;
        logic [3:0] s1, s2;
        logic       use2;
        obs_t       e_nofwd, e_fwd;
    } hz_t;

    task automatic test_hazard();
        obs_t got, exp_v;
        hz_t  tab [8];
        tab = '{
            '{1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd4, 4'd0, 1'b1, HAZ,  NORM},  // r4 in MEM, sub r5,r4,r0
            '{1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd4, 4'd0, 1'b1, HAZ,  NORM},  // still in MEM
            '{1'b0, 1'b0, 4'd0, 1'b0, 4'd4, 4'd4, 4'd0, 1'b1, NORM, NORM},  // r4 gone
            '{1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 4'd1, 4'd2, 1'b1, HAZ,  NORM},  // alu in EXE on src2
            '{1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd2, 4'd1, 1'b1, HAZ,  HAZ },  // ldr r2 / add r3,r2,r1
            '{1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd3, 4'd2, 1'b0, NORM, NORM},  // src2 not used
            '{1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd2, 4'd0, 1'b0, NORM, NORM},  // no writeback
            '{1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd1, 4'd9, 1'b1, HAZ,  NORM}   // MEM producer on src2
        };
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            bus.exe_wb_en   = tab[i].ewb;
            bus.exe_mem_rd  = tab[i].erd;
            bus.exe_dest    = tab[i].edst;
            bus.mem_wb_en   = tab[i].mwb;
            bus.mem_dest    = tab[i].mdst;
            bus.id_src1     = tab[i].s1;
            bus.id_src2     = tab[i].s2;
            bus.id_src2_use = tab[i].use2;
            sb.push_back(FWD ? tab[i].e_fwd : tab[i].e_nofwd);
            @(negedge clk);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL hazard[%0d] got=%b exp=%b", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        obs_t got, exp_v;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            if (i > 0) set_load_use();
            bus.branch_taken = (i < 2);
            sb.push_back((i < 2) ? BRANCH : HAZ);
            @(negedge clk);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL branch[%0d] got=%b exp=%b", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    // branch resolves while memory is stalled: held off until the release cycle
    task automatic test_branch_in_wait();
        obs_t got, exp_v;
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            bus.mem_acc      = (i < 5);
            bus.branch_taken = (i >= 1 && i <= 4);
            sb.push_back((i < 4) ? STALL : (i == 4) ? BRANCH : NORM);
            @(negedge clk);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL branch_in_wait[%0d] got=%b exp=%b", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    // reset lands in WAIT with cnt=1; afterwards a fresh access stalls the full 4 cycles
    task automatic test_reset_in_wait();
        obs_t got, exp_v;
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            rst         = (i == 2);
            bus.mem_acc = (i != 3);
            sb.push_back((i < 2) ? STALL : (i < 4) ? NORM : (i < 8) ? STALL : NORM);
            @(negedge clk);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL reset_in_wait[%0d] got=%b exp=%b", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    typedef struct {
        logic [3:0] s1, s2;
        logic       mwb;
        logic [3:0] mdst;
        logic       wwb;
        logic [3:0] wdst;
        logic [1:0] fa, fb;
    } fw_t;

    task automatic test_forwarding();
        obs_t got, exp_v;
        fw_t  tab [5];
        tab = '{
            '{4'd7, 4'hF, 1'b1, 4'd7, 1'b1, 4'd7, 2'd1, 2'd0},
            '{4'd7, 4'hF, 1'b0, 4'd7, 1'b1, 4'd7, 2'd2, 2'd0},
            '{4'd7, 4'hF, 1'b0, 4'd7, 1'b0, 4'd7, 2'd0, 2'd0},
            '{4'd3, 4'd7, 1'b1, 4'd7, 1'b1, 4'd3, 2'd2, 2'd1},
            '{4'd3, 4'd7, 1'b1, 4'd5, 1'b1, 4'd7, 2'd0, 2'd2}
        };
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            bus.exe_src1  = tab[i].s1;
            bus.exe_src2  = tab[i].s2;
            bus.mem_wb_en = tab[i].mwb;
            bus.mem_dest  = tab[i].mdst;
            bus.wb_wb_en  = tab[i].wwb;
            bus.wb_dest   = tab[i].wdst;
            sb.push_back({5'b11111, 3'b000, (FWD ? tab[i].fa : 2'd0), (FWD ? tab[i].fb : 2'd0), 1'b0});
            @(negedge clk);
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL forwarding[%0d] got=%b exp=%b", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mem_stall();
        test_hazard();
        test_branch();
        test_branch_in_wait();
        test_reset_in_wait();
        test_forwarding();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
